// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register file: single-entry AW/W buffers, registered B/R channels, local register taps.
// Optional byte-strobe writes are enabled by defining AXIL_SLV_WSTRB_EN.
module axi4lite_slave_regs #(
  parameter int unsigned data_width    = 32,
  parameter int unsigned address_width = 6,
  parameter int unsigned NUM_REGS      = 12
) (
  input  logic                           ACLK,
  input  logic                           ARESET_N,
  input  logic [address_width-1:0]       AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [data_width-1:0]          WDATA,
  input  logic [data_width/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [address_width-1:0]       ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [data_width-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*data_width-1:0] regs_flat,
  output logic [NUM_REGS-1:0]            reg_wr
);
  localparam int unsigned IW = address_width - 2;
  localparam int unsigned SW = data_width / 8;

  logic [data_width-1:0] regs_q [NUM_REGS];
  logic                  aw_full;
  logic                  w_full;
  logic [IW-1:0]         aw_idx;
  logic [data_width-1:0] w_data;
`ifdef AXIL_SLV_WSTRB_EN
  logic [SW-1:0]         w_strb;
`endif
  logic                  commit_c;
  logic                  aw_mapped_c;
  logic                  ar_mapped_c;
  logic                  ar_hs_c;
  logic [IW-1:0]         ar_idx_c;
  logic [data_width-1:0] rd_word_c;
  logic                  unused_ok;

  assign AWREADY     = ~aw_full;
  assign WREADY      = ~w_full;
  assign ARREADY     = ~RVALID | RREADY;
  assign commit_c    = aw_full & w_full & (~BVALID | BREADY);
  assign aw_mapped_c = 32'(aw_idx) < NUM_REGS;
  assign ar_idx_c    = ARADDR[address_width-1:2];
  assign ar_mapped_c = 32'(ar_idx_c) < NUM_REGS;
  assign ar_hs_c     = ARVALID & ARREADY;

  // Byte-lane bits of the addresses alias to the word.
`ifdef AXIL_SLV_WSTRB_EN
  assign unused_ok = &{1'b0, AWADDR[1:0], ARADDR[1:0]};
`else
  assign unused_ok = &{1'b0, AWADDR[1:0], ARADDR[1:0], WSTRB};
`endif

  // Write address / data holding buffers; capture is blocked only while full.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
`ifdef AXIL_SLV_WSTRB_EN
      w_strb  <= '0;
`endif
    end else begin
      if (AWVALID && !aw_full) begin
        aw_full <= 1'b1;
        aw_idx  <= AWADDR[address_width-1:2];
      end else if (commit_c) begin
        aw_full <= 1'b0;
      end
      if (WVALID && !w_full) begin
        w_full <= 1'b1;
        w_data <= WDATA;
`ifdef AXIL_SLV_WSTRB_EN
        w_strb <= WSTRB;
`endif
      end else if (commit_c) begin
        w_full <= 1'b0;
      end
    end
  end

  // Register commit and per-register write pulse.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit_c && (aw_idx == IW'(i))) begin
          reg_wr[i] <= 1'b1;
`ifdef AXIL_SLV_WSTRB_EN
          for (int unsigned k = 0; k < SW; k++)
            if (w_strb[k]) regs_q[i][8*k +: 8] <= w_data[8*k +: 8];
`else
          regs_q[i] <= w_data;
`endif
        end
      end
    end
  end

  // Write response: a commit on the BREADY edge re-arms BVALID.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      BVALID <= 1'b0;
      BRESP  <= 2'b00;
    end else if (commit_c) begin
      BVALID <= 1'b1;
      BRESP  <= aw_mapped_c ? 2'b00 : 2'b10;
    end else if (BREADY) begin
      BVALID <= 1'b0;
    end
  end

  // Read mux; unmapped indices match nothing and return zero.
  always_comb begin
    rd_word_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (ar_idx_c == IW'(i)) rd_word_c = regs_q[i];
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= 2'b00;
    end else if (ar_hs_c) begin
      RVALID <= 1'b1;
      RDATA  <= rd_word_c;
      RRESP  <= ar_mapped_c ? 2'b00 : 2'b10;
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*data_width +: data_width] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Scoreboard bench for axi4lite_slave_regs: directed corner cases plus randomized traffic vs. a word-array model.
module tb_axi4lite_slave_regs;
  localparam int NREG = 12;

  typedef struct packed {
    logic [NREG-1:0] mask;
    logic [31:0]     val;
  } pulse_t;

  logic             ACLK, ARESET_N;
  logic [5:0]       AWADDR, ARADDR;
  logic             AWVALID, AWREADY, WVALID, WREADY;
  logic [31:0]      WDATA, RDATA;
  logic [3:0]       WSTRB;
  logic [1:0]       BRESP, RRESP;
  logic             BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [NREG*32-1:0] regs_flat;
  logic [NREG-1:0]  reg_wr;

  int checks = 0;
  int failures = 0;
  bit rand_rdy = 0;

  logic [31:0]  model [16];
  logic [1:0]   bq [$];
  logic [33:0]  rq [$];
  pulse_t       pq [$];

  axi4lite_slave_regs dut (
    .ACLK(ACLK), .ARESET_N(ARESET_N),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_flat(regs_flat), .reg_wr(reg_wr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: word array, out-of-range indices answer SLVERR.
  function automatic void model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    pulse_t p;
    idx = int'(addr[5:2]);
    if (idx < NREG) begin
`ifdef AXIL_SLV_WSTRB_EN
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
`else
      if (strb == 4'hx) model[idx] = 'x;
      model[idx] = data;
`endif
      p.mask = NREG'(1) << idx;
      p.val  = model[idx];
      pq.push_back(p);
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endfunction

  // Monitors: pop expectations whenever the DUT presents a transfer.
  always @(negedge ACLK) begin
    if (ARESET_N) begin
      if (BVALID && BREADY) begin
        if (bq.size() == 0) check("b_unexpected", 64'(BVALID), 64'd0);
        else check("bresp", 64'(BRESP), 64'(bq.pop_front()));
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) check("r_unexpected", 64'(RVALID), 64'd0);
        else check("rresp_rdata", 64'({RRESP, RDATA}), 64'(rq.pop_front()));
      end
      if (reg_wr != '0) begin
        if (pq.size() == 0) check("reg_wr_unexpected", 64'(reg_wr), 64'd0);
        else begin
          pulse_t p;
          int idx;
          p = pq.pop_front();
          idx = 0;
          for (int i = 0; i < NREG; i++) if (p.mask[i]) idx = i;
          check("reg_wr_mask", 64'(reg_wr), 64'(p.mask));
          check("reg_on_commit", 64'(regs_flat[idx*32 +: 32]), 64'(p.val));
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
    if (rand_rdy) begin
      BREADY = ($urandom_range(0, 3) != 0);
      RREADY = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    model_write(addr, data, strb);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done)) begin
      if (!aw_done && c >= aw_dly) AWVALID = 1'b1;
      if (!w_done && c >= w_dly) WVALID = 1'b1;
      @(negedge ACLK);
      if (w_done && !aw_done) check("wready_low_while_w_full", 64'(WREADY), 64'd0);
      if (aw_done && !w_done) check("awready_low_while_aw_full", 64'(AWREADY), 64'd0);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      if (aw_hs) begin aw_done = 1; AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  WVALID = 1'b0; end
      c++;
      if (c > 300) begin
        check("write_handshake_timeout", 64'(c), 64'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [5:0] addr, input int dly);
    int idx, c;
    bit hs;
    idx = int'(addr[5:2]);
    c = 0;
    if (idx < NREG) rq.push_back({2'b00, model[idx]});
    else rq.push_back({2'b10, 32'h0});
    ARADDR = addr;
    repeat (dly) tick();
    ARVALID = 1'b1;
    do begin
      @(negedge ACLK);
      hs = ARVALID && ARREADY;
      tick();
      c++;
    end while (!hs && c < 300);
    ARVALID = 1'b0;
    if (!hs) check("read_handshake_timeout", 64'(c), 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((bq.size() + rq.size() + pq.size()) != 0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("drain_timeout", 64'(n), 64'd0);
  endtask

  // Called right after the last AW/W handshake edge, with nothing pending.
  task automatic check_latency();
    @(negedge ACLK);
    check("bvalid_before_commit", 64'(BVALID), 64'd0);
    @(negedge ACLK);
    check("bvalid_after_commit", 64'(BVALID), 64'd1);
    @(negedge ACLK);
    check("reg_wr_single_cycle", 64'(reg_wr), 64'd0);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    logic [31:0] old_v, new_v;
    for (int i = 0; i < 16; i++) model[i] = '0;
    ARESET_N = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = 4'hF; WVALID = 1'b0;
    BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_bresp_rresp_rdata", 64'({BRESP, RRESP, RDATA}), 64'd0);
    check("rst_reg_wr", 64'(reg_wr), 64'd0);
    check("rst_regs_nonzero", 64'(regs_flat != '0), 64'd0);
    check("rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
    ARESET_N = 1'b1;
    tick();

    // Same-cycle AW/W, then W three cycles ahead of AW.
    do_write(6'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    check_latency();
    wait_drain();
    do_write(6'h08, 32'h12345678, 4'hF, 3, 0);
    check_latency();
    wait_drain();
    do_read(6'h08, 0);
    wait_drain();

    // Unmapped write and read.
    do_write(6'h3C, 32'hCAFEF00D, 4'hF, 0, 0);
    wait_drain();
    do_read(6'h3C, 1);
    wait_drain();

    // BREADY stalled with a second write queued behind the response.
    BREADY = 1'b0;
    do_write(6'h3C, 32'h0BADF00D, 4'hF, 0, 0);
    do_write(6'h10, 32'hA5A55A5A, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bvalid_held", 64'(BVALID), 64'd1);
      check("bresp_stable", 64'(BRESP), 64'h2);
      check("awready_blocked", 64'(AWREADY), 64'd0);
      tick();
    end
    BREADY = 1'b1;
    tick();
    @(negedge ACLK);
    check("bvalid_rearmed", 64'(BVALID), 64'd1);
    check("bresp_second", 64'(BRESP), 64'h0);
    wait_drain();

    // RREADY stalled for three cycles.
    RREADY = 1'b0;
    do_read(6'h04, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("rvalid_held", 64'(RVALID), 64'd1);
      check("rdata_stable", 64'(RDATA), 64'hDEADBEEF);
      check("arready_blocked", 64'(ARREADY), 64'd0);
      tick();
    end
    RREADY = 1'b1;
    wait_drain();

    // Read handshake on the commit edge of the same register returns the old word.
    old_v = model[1];
    new_v = $urandom;
    rq.push_back({2'b00, old_v});
    model_write(6'h04, new_v, 4'hF);
    AWADDR = 6'h04; WDATA = new_v; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 6'h07; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    wait_drain();
    do_read(6'h05, 0);
    wait_drain();

`ifdef AXIL_SLV_WSTRB_EN
    do_write(6'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    wait_drain();
    do_write(6'h04, 32'h11223344, 4'b0101, 0, 1);
    wait_drain();
    check("wstrb_merge", 64'(regs_flat[63:32]), 64'hDE22BE44);
    do_write(6'h04, 32'hFFFFFFFF, 4'b0000, 0, 0);
    wait_drain();
    do_read(6'h04, 0);
    wait_drain();
`endif

    // Asynchronous reset with a response, a read and a half write in flight.
    BREADY = 1'b0; RREADY = 1'b0;
    do_write(6'h0C, 32'h13572468, 4'hF, 0, 0);
    tick();
    do_read(6'h0C, 0);
    AWADDR = 6'h20; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    #1;
    ARESET_N = 1'b0;
    #1;
    check("mid_rst_valids", 64'({BVALID, RVALID}), 64'd0);
    check("mid_rst_resp_data", 64'({BRESP, RRESP, RDATA}), 64'd0);
    check("mid_rst_reg_wr", 64'(reg_wr), 64'd0);
    check("mid_rst_regs_nonzero", 64'(regs_flat != '0), 64'd0);
    check("mid_rst_readies", 64'({AWREADY, WREADY}), 64'h3);
    bq.delete(); rq.delete(); pq.delete();
    for (int i = 0; i < 16; i++) model[i] = '0;
    BREADY = 1'b1; RREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET_N = 1'b1;
    tick();
    do_read(6'h0C, 0);
    wait_drain();

    // Randomized traffic, one transaction at a time, random backpressure.
    rand_rdy = 1;
    for (int n = 0; n < 250; n++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2));
      wait_drain();
    end
    rand_rdy = 0;
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    for (int i = 0; i < NREG; i++) check("final_reg", 64'(regs_flat[i*32 +: 32]), 64'(model[i]));
    check("scoreboard_empty", 64'(bq.size() + rq.size() + pq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
